// File: rtl/zap_ram_pipe_ben.sv
// Pipelined simple-dual-port RAM: byte write enables, RD_LAT-cycle registered read,
// per-byte write forwarding across every read stage. Optional zero-fill after reset: ZAP_RAM_PIPE_CLEAR_EN.
module zap_ram_pipe_ben #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clken,
  input  logic [WIDTH/8-1:0]       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_ready
);

  localparam int NB = WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd2;
`ifdef ZAP_RAM_PIPE_CLEAR_EN
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [AW-1:0] L_LAST = AW'(DEPTH - 1);
`endif

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $fatal(1, "zap_ram_pipe_ben: WIDTH must be a non-zero multiple of 8");
  end
  if (RD_LAT < 2 || RD_LAT > 6) begin : g_bad_lat
    $fatal(1, "zap_ram_pipe_ben: RD_LAT must be in 2..6");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "zap_ram_pipe_ben: DEPTH must be at least 2");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_mem_q;
  logic [NB-1:0]    r_sel;
  logic [RD_LAT-1:1] r_vld;
  logic [AW-1:0]    r_addr [1:RD_LAT-1];
  logic [WIDTH-1:0] r_buf  [1:RD_LAT-1];
  logic [WIDTH-1:0] w_prev [1:RD_LAT-1];
  logic [WIDTH-1:0] w_next [1:RD_LAT-1];
  logic             w_ready;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_rd_in_range;
  logic [NB-1:0]    w_sel_new;

  assign w_ready       = (r_state == ST_RUN);
  assign o_ready       = w_ready;
  assign w_rd_in_range = ({1'b0, i_rd_addr} < L_DEPTH);
  assign w_rd_acc      = i_clken && w_ready && i_rd_en;
  // Out-of-range writes are dropped here, so they neither reach the array nor forward.
  assign w_wr_acc      = i_clken && w_ready && (|i_wr_en) && ({1'b0, i_wr_addr} < L_DEPTH);
  assign w_sel_new     = i_wr_en & {NB{w_wr_acc && (i_wr_addr == i_rd_addr)}};

`ifdef ZAP_RAM_PIPE_CLEAR_EN
  logic [AW-1:0] r_clr_addr;
  logic          w_clr_we;

  assign w_clr_we = !i_reset && ((r_state == ST_RESET) || (r_state == ST_CLEAR));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_RESET;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state    <= ST_CLEAR;
          r_clr_addr <= r_clr_addr + AW'(1);
        end
        ST_CLEAR: begin
          if (r_clr_addr == L_LAST) r_state <= ST_RUN;
          else                      r_clr_addr <= r_clr_addr + AW'(1);
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_RESET;
      endcase
    end
  end
`else
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_RESET;
    else         r_state <= ST_RUN;
  end
`endif

  // NOTE: the array has no reset branch on purpose; resetting a memory turns it into
  // thousands of flops and blocks RAM inference.
  always_ff @(posedge i_clk) begin
`ifdef ZAP_RAM_PIPE_CLEAR_EN
    if (w_clr_we) r_mem[r_clr_addr] <= '0;
`endif
    for (int b = 0; b < NB; b++) begin
      if (w_wr_acc && i_wr_en[b]) r_mem[i_wr_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
    end
  end

  // Read-before-write array port; the same-cycle write is picked up through r_sel.
  always_ff @(posedge i_clk) begin
    if (i_clken) r_mem_q <= w_rd_in_range ? r_mem[i_rd_addr] : '0;
  end

  // NOTE: every combinational output gets a full default before any conditional
  // override, otherwise a latch is inferred.
  always_comb begin
    for (int k = 1; k < RD_LAT; k++) w_prev[k] = r_buf[k];
    for (int b = 0; b < NB; b++) begin
      if (!r_sel[b]) w_prev[1][b*8 +: 8] = r_mem_q[b*8 +: 8];
    end
  end

  always_comb begin
    for (int k = 1; k < RD_LAT; k++) begin
      w_next[k] = w_prev[k];
      for (int b = 0; b < NB; b++) begin
        if (w_wr_acc && i_wr_en[b] && (i_wr_addr == r_addr[k]))
          w_next[k][b*8 +: 8] = i_wr_data[b*8 +: 8];
      end
    end
  end

  // Datapath stages carry no reset; their validity lives in r_vld.
  always_ff @(posedge i_clk) begin
    if (i_clken) begin
      r_addr[1] <= i_rd_addr;
      r_buf[1]  <= i_wr_data;
      for (int k = 2; k < RD_LAT; k++) begin
        r_addr[k] <= r_addr[k-1];
        r_buf[k]  <= w_next[k-1];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld      <= '0;
      r_sel      <= '0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else if (i_clken) begin
      r_vld[1] <= w_rd_acc;
      for (int k = 2; k < RD_LAT; k++) r_vld[k] <= r_vld[k-1];
      r_sel      <= w_rd_acc ? w_sel_new : '0;
      o_rd_valid <= r_vld[RD_LAT-1];
      if (r_vld[RD_LAT-1]) o_rd_data <= w_next[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_zap_ram_pipe_ben.sv
// Directed bench for zap_ram_pipe_ben (WIDTH=32, DEPTH=20, RD_LAT=3).
module tb_zap_ram_pipe_ben;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 20;
  localparam int RD_LAT = 3;
  localparam int AW     = $clog2(DEPTH);
  localparam int NB     = WIDTH / 8;
`ifdef ZAP_RAM_PIPE_CLEAR_EN
  localparam int READY_LAT = DEPTH;
`else
  localparam int READY_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clken;
  logic [NB-1:0]    wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  zap_ram_pipe_ben #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .i_clk(clk), .i_reset(rst), .i_clken(clken),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_ready(ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of inputs and let the next rising edge sample them.
  task automatic drive(input logic [NB-1:0] we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    tick();
  endtask

  // Edges from reset release until o_ready, bounded; also reports any stray valid.
  task automatic wait_ready(output int n, output bit saw_valid);
    n = 0; saw_valid = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (rd_valid) saw_valid = 1'b1;
      if (ready) break;
    end
  endtask

  task automatic test_reset();
    int n; bit sv;
    rst = 1'b1; clken = 1'b1;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    #12;
    n_total++; if (rd_data !== 32'h0) $display("FAIL reset_data: got %h expected %h", rd_data, 32'h0); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rd_valid); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready); else n_pass++;
    tick();
    rst = 1'b0;
    wait_ready(n, sv);
    n_total++; if (n !== READY_LAT) $display("FAIL ready_latency: got %0d expected %0d", n, READY_LAT); else n_pass++;
  endtask

`ifdef ZAP_RAM_PIPE_CLEAR_EN
  task automatic test_clear();
    int n; bit sv;
    for (int a = 0; a < DEPTH; a++) begin
      drive('0, '0, '0, 1'b1, AW'(a));
      drive('0, '0, '0, 1'b0, '0);
      drive('0, '0, '0, 1'b0, '0);
      n_total++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h0)
        $display("FAIL clear_read[%0d]: got v=%b d=%h expected v=1 d=%h", a, rd_valid, rd_data, 32'h0);
      else n_pass++;
    end
    drive(4'hF, 5'd10, 32'h5A5A5A5A, 1'b0, '0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    wait_ready(n, sv);
    n_total++; if (n !== DEPTH) $display("FAIL clear_restart_latency: got %0d expected %0d", n, DEPTH); else n_pass++;
    drive('0, '0, '0, 1'b1, 5'd10);
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_data !== 32'h0) $display("FAIL clear_restart_data: got %h expected %h", rd_data, 32'h0); else n_pass++;
  endtask
`endif

  task automatic test_write_read();
    drive(4'hF, 5'd5, 32'hAABBCCDD, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 5'd5);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL wr_rd_early_valid: got %b expected 0", rd_valid); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b expected 1", rd_valid); else n_pass++;
    n_total++; if (rd_data !== 32'hAABBCCDD) $display("FAIL wr_rd_data: got %h expected %h", rd_data, 32'hAABBCCDD); else n_pass++;
  endtask

  task automatic test_forward();
    drive(4'hF, 5'd5, 32'h11223344, 1'b0, '0);
    drive(4'h1, 5'd5, 32'h000000EE, 1'b1, 5'd5);
    drive(4'h4, 5'd5, 32'h00770000, 1'b0, '0);
    drive(4'h8, 5'd5, 32'h99000000, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h997733EE)
      $display("FAIL fwd_bytes: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h997733EE); else n_pass++;
    drive(4'hF, 5'd8, 32'h12345678, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 5'd8);
    drive(4'h1, 5'd8, 32'h00000001, 1'b0, '0);
    drive(4'h1, 5'd8, 32'h00000002, 1'b0, '0);
    n_total++; if (rd_data !== 32'h12345602) $display("FAIL fwd_latest: got %h expected %h", rd_data, 32'h12345602); else n_pass++;
    drive(4'h2, 5'd8, 32'h00005500, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL fwd_single_valid: got %b expected 0", rd_valid); else n_pass++;
    drive('0, '0, '0, 1'b1, 5'd8);
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_data !== 32'h12345502) $display("FAIL fwd_array: got %h expected %h", rd_data, 32'h12345502); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(4'hF, 5'd6, 32'h01020304, 1'b0, '0);
    drive(4'hF, 5'd7, 32'h0A0B0C0D, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 5'd5);
    drive('0, '0, '0, 1'b1, 5'd6);
    drive('0, '0, '0, 1'b1, 5'd7);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h997733EE)
      $display("FAIL b2b_0: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h997733EE); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h01020304)
      $display("FAIL b2b_1: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h01020304); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0A0B0C0D)
      $display("FAIL b2b_2: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h0A0B0C0D); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL b2b_end: got %b expected 0", rd_valid); else n_pass++;
  endtask

  task automatic test_stall();
    drive(4'hF, 5'd9, 32'hCAFEF00D, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 5'd9);
    clken = 1'b0;
    drive(4'hF, 5'd9, 32'hFFFFFFFF, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 5'd9);
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL stall_frozen: got %b expected 0", rd_valid); else n_pass++;
    clken = 1'b1;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL stall_early: got %b expected 0", rd_valid); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'hCAFEF00D)
      $display("FAIL stall_result: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'hCAFEF00D); else n_pass++;
    clken = 1'b0;
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'hCAFEF00D)
      $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'hCAFEF00D); else n_pass++;
    clken = 1'b1;
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL stall_no_extra: got %b expected 0", rd_valid); else n_pass++;
    drive('0, '0, '0, 1'b1, 5'd9);
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_data !== 32'hCAFEF00D) $display("FAIL stall_write_dropped: got %h expected %h", rd_data, 32'hCAFEF00D); else n_pass++;
  endtask

  task automatic test_oor();
    drive(4'hF, 5'd25, 32'hDEADBEEF, 1'b0, '0);
    drive(4'hF, 5'd19, 32'h13579BDF, 1'b0, '0);
    drive('0, '0, '0, 1'b1, 5'd25);
    drive('0, '0, '0, 1'b1, 5'd19);
    drive(4'hF, 5'd25, 32'hFFFFFFFF, 1'b1, 5'd25);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0)
      $display("FAIL oor_read: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h0); else n_pass++;
    drive('0, '0, '0, 1'b1, 5'd5);
    n_total++; if (rd_data !== 32'h13579BDF) $display("FAIL oor_last_addr: got %h expected %h", rd_data, 32'h13579BDF); else n_pass++;
    drive('0, '0, '0, 1'b1, 5'd9);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h0)
      $display("FAIL oor_same_cycle: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h0); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_data !== 32'h997733EE) $display("FAIL oor_alias5: got %h expected %h", rd_data, 32'h997733EE); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    n_total++; if (rd_data !== 32'hCAFEF00D) $display("FAIL oor_alias9: got %h expected %h", rd_data, 32'hCAFEF00D); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int n; bit sv;
    drive('0, '0, '0, 1'b1, 5'd6);
    drive('0, '0, '0, 1'b1, 5'd7);
    drive('0, '0, '0, 1'b1, 5'd19);
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h01020304)
      $display("FAIL mid_pre: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, 32'h01020304); else n_pass++;
    rd_addr = 5'd5;
    #2 rst = 1'b1;
    #1;
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 32'h0)
      $display("FAIL mid_reset_now: got v=%b d=%h expected v=0 d=%h", rd_valid, rd_data, 32'h0); else n_pass++;
    drive('0, '0, '0, 1'b0, '0);
    drive('0, '0, '0, 1'b0, '0);
    rst = 1'b0;
    wait_ready(n, sv);
    for (int i = 0; i < RD_LAT + 3; i++) begin
      tick();
      if (rd_valid) sv = 1'b1;
    end
    n_total++; if (sv !== 1'b0) $display("FAIL mid_no_valid: got %b expected 0", sv); else n_pass++;
    n_total++; if (n !== READY_LAT) $display("FAIL mid_ready_latency: got %0d expected %0d", n, READY_LAT); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef ZAP_RAM_PIPE_CLEAR_EN
    test_clear();
`endif
    test_write_read();
    test_forward();
    test_back_to_back();
    test_stall();
    test_oor();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
